// File: rtl/cal_polar2rect_pkg.sv
// Shared CORDIC constants for the polar/rectangular converters: arctangent table,
// gain compensation constant and default datapath sizing.
package cal_polar2rect_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 16;
  localparam int ITER_DEF  = 12;
  localparam int GUARD_DEF = 4;
  localparam int K_Q15     = 19898;

  // round(atan(2^-k) * 2^15 / pi), rescaled for angle widths other than 16 bits
  function automatic int atan_val(input int k, input int aw);
    int t;
    case (k)
      0:       t = 8192;
      1:       t = 4836;
      2:       t = 2555;
      3:       t = 1297;
      4:       t = 651;
      5:       t = 326;
      6:       t = 163;
      7:       t = 81;
      8:       t = 41;
      9:       t = 20;
      10:      t = 10;
      11:      t = 5;
      12:      t = 3;
      13:      t = 1;
      default: t = 0;
    endcase
    if (aw >= 16) return t <<< (aw - 16);
    return t >>> (16 - aw);
  endfunction

endpackage

// File: rtl/cal_polar2rect_if.sv
// Sample stream into the polar-to-rectangular converter and the result stream out of it.
interface cal_polar2rect_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic                 sample_val;
  logic [DW-1:0]        sample_mag;
  logic [AW-1:0]        sample_angle;
  logic                 result_val;
  logic signed [DW:0]   result_re;
  logic signed [DW:0]   result_im;

  modport master (
    output sample_val, sample_mag, sample_angle,
    input  result_val, result_re, result_im
  );

  modport slave (
    input  sample_val, sample_mag, sample_angle,
    output result_val, result_re, result_im
  );
endinterface

// File: rtl/cal_polar2rect_rot_stage.sv
// One registered CORDIC rotation-mode micro-rotation: rotates (x,y) towards the residual
// angle z by +-atan(2^-SHIFT). Latency 1 clk, no backpressure.
module cal_polar2rect_rot_stage #(
  parameter int SHIFT    = 0,
  parameter int ATAN_VAL = 8192,
  parameter int XW       = 14,
  parameter int ZW       = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  output logic signed [XW-1:0] x_rot,
  output logic signed [XW-1:0] y_rot,
  output logic signed [ZW-1:0] z_rot
);

  localparam logic signed [ZW-1:0] ATAN_Z = ZW'(ATAN_VAL);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x >>> SHIFT;
  assign y_sh = y >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_rot <= '0;
      y_rot <= '0;
      z_rot <= '0;
    end else if (!z[ZW-1]) begin
      x_rot <= x - y_sh;
      y_rot <= y + x_sh;
      z_rot <= z - ATAN_Z;
    end else begin
      x_rot <= x + y_sh;
      y_rot <= y - x_sh;
      z_rot <= z + ATAN_Z;
    end
  end

endmodule

// File: rtl/cal_polar2rect.sv
// Pipelined CORDIC polar-to-rectangular converter: quadrant fold, ITER micro-rotations,
// gain compensation with round/clamp. Latency ITER+2 clk, one sample per clk, no backpressure.
module cal_polar2rect
  import cal_polar2rect_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int ITER  = ITER_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cal_polar2rect_if.slave  bus
);

  localparam int XW  = DW + 2 + GUARD;
  localparam int ZW  = AW + 1;
  localparam int LAT = ITER + 2;
  localparam int PW  = XW + 16;

  localparam logic signed [15:0]   K_S  = 16'(K_Q15);
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (14 + GUARD);
  localparam logic signed [PW-1:0] LIM  = PW'((1 << DW) - 1);

  logic signed [XW-1:0] xs [ITER+1];
  logic signed [XW-1:0] ys [ITER+1];
  logic signed [ZW-1:0] zs [ITER+1];

  logic signed [XW-1:0] x0;
  logic signed [XW-1:0] y0;
  logic signed [ZW-1:0] z0;
  logic [LAT-1:0]       val_pipe;

  logic                 fold;
  logic signed [XW-1:0] mag_ext;
  logic [AW-1:0]        ang_fold;

  // Magnitude enters with GUARD fractional bits; |angle| >= 90deg folds by 180deg and negates x.
  assign fold     = bus.sample_angle[AW-1] ^ bus.sample_angle[AW-2];
  assign mag_ext  = signed'({2'b00, bus.sample_mag, {GUARD{1'b0}}});
  assign ang_fold = fold ? {~bus.sample_angle[AW-1], bus.sample_angle[AW-2:0]}
                         : bus.sample_angle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0;
      y0 <= '0;
      z0 <= '0;
    end else begin
      x0 <= fold ? -mag_ext : mag_ext;
      y0 <= '0;
      z0 <= signed'({ang_fold[AW-1], ang_fold});
    end
  end

  assign xs[0] = x0;
  assign ys[0] = y0;
  assign zs[0] = z0;

  for (genvar k = 0; k < ITER; k++) begin : g_stage
    cal_polar2rect_rot_stage #(
      .SHIFT    (k),
      .ATAN_VAL (atan_val(k, AW)),
      .XW       (XW),
      .ZW       (ZW)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (xs[k]),
      .y     (ys[k]),
      .z     (zs[k]),
      .x_rot (xs[k+1]),
      .y_rot (ys[k+1]),
      .z_rot (zs[k+1])
    );
  end

  // Residual angle after the last rotation carries no information for the output.
  logic z_unused;
  assign z_unused = ^zs[ITER];

  logic signed [PW-1:0] prod_re;
  logic signed [PW-1:0] prod_im;
  logic signed [PW-1:0] scl_re;
  logic signed [PW-1:0] scl_im;

  assign prod_re = PW'(xs[ITER]) * PW'(K_S);
  assign prod_im = PW'(ys[ITER]) * PW'(K_S);
  assign scl_re  = (prod_re + HALF) >>> (15 + GUARD);
  assign scl_im  = (prod_im + HALF) >>> (15 + GUARD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result_re <= '0;
      bus.result_im <= '0;
    end else begin
      if (scl_re > LIM)       bus.result_re <= LIM[DW:0];
      else if (scl_re < -LIM) bus.result_re <= -LIM[DW:0];
      else                    bus.result_re <= scl_re[DW:0];
      if (scl_im > LIM)       bus.result_im <= LIM[DW:0];
      else if (scl_im < -LIM) bus.result_im <= -LIM[DW:0];
      else                    bus.result_im <= scl_im[DW:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_pipe <= '0;
    else        val_pipe <= {val_pipe[LAT-2:0], bus.sample_val};
  end

  assign bus.result_val = val_pipe[LAT-1];

endmodule

// File: tb/tb_cal_polar2rect.sv
// Randomised scoreboard bench for cal_polar2rect against a floating-point trig model.
module tb_cal_polar2rect;

  localparam int LAT = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cal_polar2rect_if bus();

  cal_polar2rect dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int mag;
    int angle;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input int act, input int req, input int tol);
    int d;
    checks++;
    d = act - req;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (tol %0d) cyc=%0d", name, act, req, tol, cyc);
    end
  endfunction

  function automatic int model(input int mag, input int angle, input bit imag);
    int  sa;
    real a;
    real v;
    sa = (angle >= 32768) ? angle - 65536 : angle;
    a  = $itor(sa) * 3.14159265358979323846 / 32768.0;
    v  = $itor(mag) * (imag ? $sin(a) : $cos(a));
    return int'(v);
  endfunction

  task automatic send(input int mag, input int angle);
    @(posedge clk);
    #1;
    bus.sample_val   = 1'b1;
    bus.sample_mag   = 8'(mag);
    bus.sample_angle = 16'(angle);
    sbq.push_back('{mag, angle, cyc + LAT});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.sample_val   = 1'b0;
      bus.sample_mag   = 8'($urandom);
      bus.sample_angle = 16'($urandom);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.result_val) begin
        if (sbq.size() == 0) begin
          chk("unexpected_val", 1, 0, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("latency", cyc, mon_e.due, 0);
          chk("real", int'(bus.result_re), model(mon_e.mag, mon_e.angle, 1'b0),
              (mon_e.mag == 0) ? 0 : 1);
          chk("imag", int'(bus.result_im), model(mon_e.mag, mon_e.angle, 1'b1),
              (mon_e.mag == 0) ? 0 : 1);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("missing_val", 0, 1, 0);
        void'(sbq.pop_front());
      end
    end
  end

  int lens[3] = '{1, 3, 7};
  int gaps[3] = '{0, 1, 5};

  initial begin
    bus.sample_val   = 1'b0;
    bus.sample_mag   = '0;
    bus.sample_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_val", int'(bus.result_val), 0, 0);
    chk("reset_real", int'(bus.result_re), 0, 0);
    chk("reset_imag", int'(bus.result_im), 0, 0);
    #1 rst_n = 1'b1;
    idle(2);

    // cardinal and diagonal angles
    send(100, 16'h0000);
    send(100, 16'h4000);
    send(100, 16'h8000);
    send(100, 16'hC000);
    send(255, 16'h2000);
    send(255, 16'hE000);
    idle(3);

    for (int i = 0; i < 10; i++) send(0, int'($urandom_range(0, 65535)));
    idle(2);

    for (int i = 0; i < 256; i++) send(255, i * 257);
    idle(4);

    for (int b = 0; b < 3; b++) begin
      for (int g = 0; g < 3; g++) begin
        for (int n = 0; n < lens[b]; n++)
          send(int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)));
        idle(gaps[g] == 0 ? 0 : gaps[g]);
      end
    end
    idle(2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0)
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)));
      else
        idle(1);
    end

    // reset with the pipeline full and outputs streaming
    for (int i = 0; i < 22; i++) send(int'($urandom_range(50, 255)), int'($urandom_range(0, 65535)));
    @(posedge clk);
    #2;
    bus.sample_val = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_val", int'(bus.result_val), 0, 0);
    chk("mid_reset_real", int'(bus.result_re), 0, 0);
    chk("mid_reset_imag", int'(bus.result_im), 0, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(LAT + 6);
    send(200, 16'h1234);
    idle(1);

    for (int t = 0; t < 100 && sbq.size() > 0; t++) @(posedge clk);
    chk("drain_pending", sbq.size(), 0, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
